risc_control_unit: RTL and testbench
====================================

Name:
risc_control_unit

Overview:
- Moore-style multicycle controller for the 16-bit RISC CPU.
- Sits directly upstream of the datapath (PC, IR, address mux, 256x16 memory, write-data mux, register file, ALU) and drives every datapath control strobe.
- Sequences fetch, decode and execute from the latched instruction word.
- Consumes the register-file zero flag for conditional jumps.

Parameters:
- DW, 16, instruction and data width.
- AW, 8, PC and memory address width.
- RA, 4, register-file address width (16 registers).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; forces state INIT at the next rising edge.
- ir_in  in  DW  current IR contents. Field layout: [15:12] opcode, [11:8] ra, [7:4] rb, [3:0] rc, [7:0] d/imm.
- rp_zero  in  1  high when read_P == 16'h0000.
- pc_clr  out  1  clear PC to 0.
- pc_ld  out  1  load PC from d (absolute jump).
- pc_inc  out  1  PC <= PC+1.
- ir_ld  out  1  IR <= memory data_out.
- data_addr_sel  out  1  memory address source: 0 = PC, 1 = d.
- rd  out  1  memory read.
- wr  out  1  memory write; data is read_P.
- rf_sel  out  2  register write-data source: 00 = ALU, 01 = memory, 10 = sign-extended imm; 11 is not driven.
- w_addr  out  RA  register write address.
- w_wr  out  1  register write enable.
- rp_addr  out  RA  port-P read address.
- rd_P  out  1  port-P read enable.
- rq_addr  out  RA  port-Q read address.
- rd_Q  out  1  port-Q read enable.
- alu_sel  out  2  ALU operation: 00 = pass P, 01 = P+Q, 10 = P-Q, 11 = P&Q.
- d  out  AW  ir_in[7:0], driven combinationally at all times.
- halted  out  1  high in HALT.
- state_out  out  4  state code, for debug and monitor.

Behaviour:
- States: INIT=0, FETCH=1, DECODE=2, LOAD=3, STORE=4, ADD=5, LOADI=6, SUB=7, JMPZ=8, JMPZ_J=9, AND=10, HALT=15.
- All outputs are decoded from state and IR fields only. No output depends combinationally on rp_zero.
- Default for every strobe is 0.
- Reset: state <= INIT. Outputs in INIT: pc_clr=1, all other strobes 0, halted=0, state_out=0.
- INIT: pc_clr=1 -> FETCH.
- FETCH: data_addr_sel=0, rd=1, ir_ld=1, pc_inc=1 -> DECODE.
  - IR and PC update on the edge that leaves FETCH.
- DECODE: no strobes. Next state by opcode:
  - 0 -> LOAD, 1 -> STORE, 2 -> ADD, 3 -> LOADI, 4 -> SUB, 5 -> JMPZ, 6 -> AND, F -> HALT.
  - Opcodes 7..E are NOPs and go -> FETCH.
- LOAD (Ra <= M[d]): data_addr_sel=1, rd=1, rf_sel=01, w_addr=ra, w_wr=1 -> FETCH.
- STORE (M[d] <= Ra): data_addr_sel=1, wr=1, rp_addr=ra, rd_P=1 -> FETCH.
- ADD / SUB / AND (Ra <= Rb op Rc):
  - rp_addr=rb, rd_P=1, rq_addr=rc, rd_Q=1.
  - alu_sel=01 / 10 / 11 respectively.
  - rf_sel=00, w_addr=ra, w_wr=1 -> FETCH.
- LOADI (Ra <= sext(imm8)): rf_sel=10, w_addr=ra, w_wr=1 -> FETCH.
- JMPZ: rp_addr=ra, rd_P=1. Next state: rp_zero sampled at the clock edge, 1 -> JMPZ_J, 0 -> FETCH.
- JMPZ_J: pc_ld=1 (PC <= d) -> FETCH.
- HALT: halted=1, no strobes. Stays in HALT until reset.
- Latency: 3 cycles per instruction (FETCH, DECODE, EXEC); a taken JMPZ takes 4.
- Exclusivity invariants, which must hold in every state:
  - rd and wr are never both 1.
  - At most one of pc_clr, pc_ld, pc_inc is 1.
  - w_wr=1 implies rf_sel != 11.
- Reset asserted in any state, including mid-instruction or HALT: the next state is INIT.
  - Any write strobe in the current cycle still completes.
- Unused state codes (11..14) -> INIT.

Test Plan:
- Reset for 1 edge, then release -> state_out sequence 0,1,2; pc_clr=1 only in INIT; first FETCH has rd=1, ir_ld=1, pc_inc=1, data_addr_sel=0.
- ir_in=16'h3105 (LOADI R1,#5) -> states FETCH, DECODE, LOADI; in LOADI w_wr=1, w_addr=1, rf_sel=10; then back to FETCH; 3 cycles total.
- ir_in=16'h2312 (ADD R3=R1+R2) then 16'h4312 (SUB) -> in EXEC, rp_addr=1, rq_addr=2, w_addr=3, alu_sel=01, then 10 for SUB.
- ir_in=16'h1240 (STORE R2 to M[0x40]) -> wr=1, rd=0, data_addr_sel=1, d=8'h40, rp_addr=2; ir_in=16'h0540 (LOAD) -> rd=1, rf_sel=01, w_addr=5.
- ir_in=16'h5120 (JMPZ) with rp_zero=1 -> JMPZ_J with pc_ld=1, d=8'h20 (4 cycles); with rp_zero=0 -> FETCH after JMPZ with pc_ld never asserted.
- ir_in=16'hF000 -> HALT, halted=1 for 20 cycles with all strobes 0; ir_in=16'h9000 -> NOP back to FETCH; reset asserted during ADD -> INIT on the next edge.

Source files
------------

// File: rtl/risc_control_unit.sv
// Moore multicycle controller for the 16-bit RISC CPU.
// Sequences fetch/decode/execute and drives every datapath control strobe.
module risc_control_unit #(
    parameter int DW = 16,
    parameter int AW = 8,
    parameter int RA = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] ir_in,
    input  logic          rp_zero,
    output logic          pc_clr,
    output logic          pc_ld,
    output logic          pc_inc,
    output logic          ir_ld,
    output logic          data_addr_sel,
    output logic          rd,
    output logic          wr,
    output logic [1:0]    rf_sel,
    output logic [RA-1:0] w_addr,
    output logic          w_wr,
    output logic [RA-1:0] rp_addr,
    output logic          rd_P,
    output logic [RA-1:0] rq_addr,
    output logic          rd_Q,
    output logic [1:0]    alu_sel,
    output logic [AW-1:0] d,
    output logic          halted,
    output logic [3:0]    state_out
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_LOADI  = 4'd6,
        S_SUB    = 4'd7,
        S_JMPZ   = 4'd8,
        S_JMPZ_J = 4'd9,
        S_AND    = 4'd10,
        S_HALT   = 4'd15
    } state_t;

    state_t state, next_state;

    logic [3:0]    opcode;
    logic [RA-1:0] ra, rb, rc;

    assign opcode    = ir_in[15:12];
    assign ra        = ir_in[11:8];
    assign rb        = ir_in[7:4];
    assign rc        = ir_in[3:0];
    assign d         = ir_in[AW-1:0];
    assign state_out = state;

    always_ff @(posedge clk) begin
        if (reset) state <= S_INIT;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = S_INIT;
        pc_clr        = 1'b0;
        pc_ld         = 1'b0;
        pc_inc        = 1'b0;
        ir_ld         = 1'b0;
        data_addr_sel = 1'b0;
        rd            = 1'b0;
        wr            = 1'b0;
        rf_sel        = 2'b00;
        w_addr        = '0;
        w_wr          = 1'b0;
        rp_addr       = '0;
        rd_P          = 1'b0;
        rq_addr       = '0;
        rd_Q          = 1'b0;
        alu_sel       = 2'b00;
        halted        = 1'b0;
        case (state)
            S_INIT: begin
                pc_clr     = 1'b1;
                next_state = S_FETCH;
            end
            S_FETCH: begin
                rd         = 1'b1;
                ir_ld      = 1'b1;
                pc_inc     = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    4'h0:    next_state = S_LOAD;
                    4'h1:    next_state = S_STORE;
                    4'h2:    next_state = S_ADD;
                    4'h3:    next_state = S_LOADI;
                    4'h4:    next_state = S_SUB;
                    4'h5:    next_state = S_JMPZ;
                    4'h6:    next_state = S_AND;
                    4'hF:    next_state = S_HALT;
                    default: next_state = S_FETCH;
                endcase
            end
            S_LOAD: begin
                data_addr_sel = 1'b1;
                rd            = 1'b1;
                rf_sel        = 2'b01;
                w_addr        = ra;
                w_wr          = 1'b1;
                next_state    = S_FETCH;
            end
            S_STORE: begin
                data_addr_sel = 1'b1;
                wr            = 1'b1;
                rp_addr       = ra;
                rd_P          = 1'b1;
                next_state    = S_FETCH;
            end
            S_ADD, S_SUB, S_AND: begin
                rp_addr    = rb;
                rd_P       = 1'b1;
                rq_addr    = rc;
                rd_Q       = 1'b1;
                alu_sel    = (state == S_ADD) ? 2'b01 :
                             (state == S_SUB) ? 2'b10 : 2'b11;
                rf_sel     = 2'b00;
                w_addr     = ra;
                w_wr       = 1'b1;
                next_state = S_FETCH;
            end
            S_LOADI: begin
                rf_sel     = 2'b10;
                w_addr     = ra;
                w_wr       = 1'b1;
                next_state = S_FETCH;
            end
            S_JMPZ: begin
                // rp_zero only steers the next state; no output depends on it.
                rp_addr    = ra;
                rd_P       = 1'b1;
                next_state = rp_zero ? S_JMPZ_J : S_FETCH;
            end
            S_JMPZ_J: begin
                pc_ld      = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_risc_control_unit.sv
// Directed bench for risc_control_unit: walks each instruction class
// through fetch/decode/execute and checks strobes against hand-computed vectors.
module tb_risc_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ir_in;
    logic        rp_zero;
    logic        pc_clr, pc_ld, pc_inc, ir_ld, data_addr_sel, rd, wr;
    logic [1:0]  rf_sel;
    logic [3:0]  w_addr;
    logic        w_wr;
    logic [3:0]  rp_addr;
    logic        rd_P;
    logic [3:0]  rq_addr;
    logic        rd_Q;
    logic [1:0]  alu_sel;
    logic [7:0]  d;
    logic        halted;
    logic [3:0]  state_out;

    int tests_run = 0;
    int tests_failed = 0;

    // {pc_clr,pc_ld,pc_inc,ir_ld,data_addr_sel,rd,wr,w_wr,rd_P,rd_Q,halted}
    localparam logic [10:0] V_INIT   = 11'b10000000000;
    localparam logic [10:0] V_FETCH  = 11'b00110100000;
    localparam logic [10:0] V_NONE   = 11'b00000000000;
    localparam logic [10:0] V_LOADI  = 11'b00000001000;
    localparam logic [10:0] V_ALU    = 11'b00000001110;
    localparam logic [10:0] V_STORE  = 11'b00001010100;
    localparam logic [10:0] V_LOAD   = 11'b00001101000;
    localparam logic [10:0] V_JMPZ   = 11'b00000000100;
    localparam logic [10:0] V_JMPZ_J = 11'b01000000000;
    localparam logic [10:0] V_HALT   = 11'b00000000001;

    logic [10:0] strobes;
    assign strobes = {pc_clr, pc_ld, pc_inc, ir_ld, data_addr_sel, rd, wr,
                      w_wr, rd_P, rd_Q, halted};

    risc_control_unit dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .rp_zero(rp_zero),
        .pc_clr(pc_clr), .pc_ld(pc_ld), .pc_inc(pc_inc), .ir_ld(ir_ld),
        .data_addr_sel(data_addr_sel), .rd(rd), .wr(wr), .rf_sel(rf_sel),
        .w_addr(w_addr), .w_wr(w_wr), .rp_addr(rp_addr), .rd_P(rd_P),
        .rq_addr(rq_addr), .rd_Q(rd_Q), .alu_sel(alu_sel), .d(d),
        .halted(halted), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [3:0] st,
                                input logic [10:0] vec);
        check({tag, ".state"}, 32'(state_out), 32'(st));
        check({tag, ".strobes"}, 32'(strobes), 32'(vec));
    endtask

    // From a sampled FETCH: present ir, step through DECODE into EXEC.
    task automatic to_exec(input string tag, input logic [15:0] ir);
        ir_in = ir;
        tick();
        expect_state({tag, ".decode"}, 4'd2, V_NONE);
        tick();
    endtask

    // Invariants sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("inv_rd_wr", 32'(rd & wr), 32'd0);
            check("inv_pc_onehot", 32'(int'(pc_clr) + int'(pc_ld) + int'(pc_inc) > 1), 32'd0);
            check("inv_rf_sel", 32'(w_wr && rf_sel == 2'b11), 32'd0);
        end
    end

    initial begin
        reset = 1'b1; ir_in = 16'h0000; rp_zero = 1'b0;
        tick();
        expect_state("reset", 4'd0, V_INIT);
        reset = 1'b0;
        tick();
        expect_state("fetch0", 4'd1, V_FETCH);

        // LOADI R1,#5
        to_exec("loadi", 16'h3105);
        expect_state("loadi", 4'd6, V_LOADI);
        check("loadi.w_addr", 32'(w_addr), 32'd1);
        check("loadi.rf_sel", 32'(rf_sel), 32'd2);
        tick();
        expect_state("loadi.back", 4'd1, V_FETCH);

        // ADD / SUB / AND R3 = R1 op R2
        to_exec("add", 16'h2312);
        expect_state("add", 4'd5, V_ALU);
        check("add.rp", 32'(rp_addr), 32'd1);
        check("add.rq", 32'(rq_addr), 32'd2);
        check("add.w_addr", 32'(w_addr), 32'd3);
        check("add.alu", 32'(alu_sel), 32'd1);
        check("add.rf_sel", 32'(rf_sel), 32'd0);
        tick();
        to_exec("sub", 16'h4312);
        expect_state("sub", 4'd7, V_ALU);
        check("sub.alu", 32'(alu_sel), 32'd2);
        check("sub.w_addr", 32'(w_addr), 32'd3);
        tick();
        to_exec("and", 16'h6312);
        expect_state("and", 4'd10, V_ALU);
        check("and.alu", 32'(alu_sel), 32'd3);
        tick();

        // STORE R2 -> M[0x40]; LOAD R5 <- M[0x40]
        to_exec("store", 16'h1240);
        expect_state("store", 4'd4, V_STORE);
        check("store.d", 32'(d), 32'h40);
        check("store.rp", 32'(rp_addr), 32'd2);
        tick();
        to_exec("load", 16'h0540);
        expect_state("load", 4'd3, V_LOAD);
        check("load.rf_sel", 32'(rf_sel), 32'd1);
        check("load.w_addr", 32'(w_addr), 32'd5);
        check("load.d", 32'(d), 32'h40);
        tick();
        expect_state("load.back", 4'd1, V_FETCH);

        // JMPZ taken: 4 cycles
        to_exec("jmpz_t", 16'h5120);
        expect_state("jmpz_t", 4'd8, V_JMPZ);
        check("jmpz_t.rp", 32'(rp_addr), 32'd1);
        rp_zero = 1'b1;
        #1;
        check("jmpz_t.no_comb", 32'(strobes), 32'(V_JMPZ));
        tick();
        rp_zero = 1'b0;
        expect_state("jmpz_j", 4'd9, V_JMPZ_J);
        check("jmpz_j.d", 32'(d), 32'h20);
        tick();
        expect_state("jmpz_t.back", 4'd1, V_FETCH);

        // JMPZ not taken
        to_exec("jmpz_n", 16'h5120);
        expect_state("jmpz_n", 4'd8, V_JMPZ);
        tick();
        expect_state("jmpz_n.back", 4'd1, V_FETCH);

        // NOP
        to_exec("nop", 16'h9000);
        expect_state("nop", 4'd1, V_FETCH);

        // HALT holds for 20 cycles, then reset recovers
        to_exec("halt", 16'hF000);
        for (int i = 0; i < 20; i++) begin
            expect_state("halt", 4'd15, V_HALT);
            tick();
        end
        reset = 1'b1;
        tick();
        expect_state("halt.reset", 4'd0, V_INIT);
        reset = 1'b0;
        tick();
        expect_state("refetch", 4'd1, V_FETCH);

        // Reset mid-instruction
        to_exec("add2", 16'h2312);
        expect_state("add2", 4'd5, V_ALU);
        reset = 1'b1;
        tick();
        expect_state("add2.reset", 4'd0, V_INIT);
        reset = 1'b0;
        tick();
        expect_state("add2.refetch", 4'd1, V_FETCH);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
